// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding
// and the iteration-counter width helper.
package mult_pkg;

  // 2'd3 is unused and decoded as IDLE by the consumers of this type
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..n inclusive
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder: every carry is a flat sum-of-products of
// generate/propagate terms and Cin, not a ripple chain.
module carry_lookahead_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         prod;
  logic         term;

  assign g = A & B;
  assign p = A ^ B;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]Cin
  always_comb begin
    c    = '0;
    prod = 1'b0;
    term = 1'b0;
    c[0] = Cin;
    for (int unsigned i = 0; i < N; i++) begin
      term = 1'b0;
      for (int unsigned j = 0; j <= i; j++) begin
        prod = g[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          prod = prod & p[k];
        end
        term = term | prod;
      end
      prod = Cin;
      for (int unsigned k = 0; k <= i; k++) begin
        prod = prod & p[k];
      end
      c[i+1] = term | prod;
    end
  end

  assign Sum  = p ^ c[N-1:0];
  assign Cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned NxN shift-add multiplier: one add-and-shift per cycle through
// the carry-lookahead adder, 2N-bit product after N iterations.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int unsigned      CNT_W    = cnt_w(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     m;
  logic [N-1:0]     h;
  logic [N-1:0]     l;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     add_b;
  logic [N-1:0]     sum;
  logic             cout;
  logic [N-1:0]     h_nx;
  logic [N-1:0]     l_nx;
  logic             last;

  assign add_b = l[0] ? m : '0;

  carry_lookahead_adder #(.N(N)) u_cla (
    .A    (h),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // {H,L} <= {Cout,Sum,L} >> 1
  assign h_nx = {cout, sum[N-1:1]};
  assign l_nx = {sum[0], l[N-1:1]};
  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = IDLE;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        state_nx = last ? DONE : RUN;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = start ? RUN : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      h   <= '0;
      l   <= '0;
      cnt <= '0;
      P   <= '0;
    end else begin
      case (state)
        RUN: begin
          h   <= h_nx;
          l   <= l_nx;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            P <= {h_nx, l_nx};
          end
        end
        DONE: begin
        end
        default: begin
          if (start) begin
            m   <= A;
            h   <= '0;
            l   <= B;
            cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at N=4.
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Drives one request and observes cycles until done (bounded to 20).
  // lat is the number of cycles from the accepting edge to done, -1 on timeout.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit hold, input bit scramble,
                        output int lat, output int nbusy, output int nboth);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    lat = -1;
    nbusy = 0;
    nboth = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (scramble) begin
        A = 4'd7;
        B = 4'd7;
      end
      if (busy) nbusy++;
      if (busy && done) nboth++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    A = 4'd3;
    B = 4'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (P !== 8'h00) begin n_err++; $display("FAIL reset_p: got %h want 00", P); end
      start = ~start;
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", done); end
      n_cmp++; if (P !== 8'h00) begin n_err++; $display("FAIL idle_p: got %h want 00", P); end
    end
  endtask

  task automatic test_basic;
    int lat, nbusy, nboth;
    run_op(4'd6, 4'd5, 1'b0, 1'b0, lat, nbusy, nboth);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", lat); end
    n_cmp++; if (nbusy !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", nbusy); end
    n_cmp++; if (nboth !== 0) begin n_err++; $display("FAIL basic_busy_done_overlap: got %0d want 0", nboth); end
    n_cmp++; if (P !== 8'h1E) begin n_err++; $display("FAIL basic_p: got %h want 1e", P); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (P !== 8'h1E) begin n_err++; $display("FAIL hold_p: got %h want 1e", P); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL hold_done: got %b want 0", done); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nbusy, nboth;
    run_op(4'd15, 4'd15, 1'b0, 1'b0, lat, nbusy, nboth);
    n_cmp++; if (P !== 8'hE1) begin n_err++; $display("FAIL b2b_15x15: got %h want e1", P); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_15x15_latency: got %0d want 5", lat); end
    run_op(4'd0, 4'd9, 1'b0, 1'b0, lat, nbusy, nboth);
    n_cmp++; if (P !== 8'h00) begin n_err++; $display("FAIL b2b_0x9: got %h want 00", P); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_0x9_latency: got %0d want 5", lat); end
    run_op(4'd1, 4'd15, 1'b0, 1'b0, lat, nbusy, nboth);
    n_cmp++; if (P !== 8'h0F) begin n_err++; $display("FAIL b2b_1x15: got %h want 0f", P); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_1x15_latency: got %0d want 5", lat); end
  endtask

  task automatic test_ignore_start;
    int lat, nbusy, nboth;
    run_op(4'd10, 4'd3, 1'b1, 1'b1, lat, nbusy, nboth);
    n_cmp++; if (P !== 8'h1E) begin n_err++; $display("FAIL held_p: got %h want 1e", P); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL held_latency: got %0d want 5", lat); end
    n_cmp++; if (nbusy !== 4) begin n_err++; $display("FAIL held_busy_cycles: got %0d want 4", nbusy); end
    // start still high through the DONE edge: must not launch a new op
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_after_done_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL held_second_done: got %b want 0", done); end
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_idle_busy: got %b want 0", busy); end
    n_cmp++; if (P !== 8'h1E) begin n_err++; $display("FAIL held_p_stable: got %h want 1e", P); end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    A = 4'd13;
    B = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy_async: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrun_done_async: got %b want 0", done); end
    n_cmp++; if (P !== 8'h00) begin n_err++; $display("FAIL midrun_p_async: got %h want 00", P); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrun_done_after: got %b want 0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy_after: got %b want 0", busy); end
      n_cmp++; if (P !== 8'h00) begin n_err++; $display("FAIL midrun_p_after: got %h want 00", P); end
    end
  endtask

  task automatic test_exhaustive;
    int lat, nbusy, nboth;
    logic [7:0] exp_p;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_p = 8'(a * b);
        run_op(4'(a), 4'(b), 1'b0, 1'b0, lat, nbusy, nboth);
        n_cmp++; if (P !== exp_p) begin n_err++; $display("FAIL exh_p %0dx%0d: got %h want %h", a, b, P, exp_p); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL exh_latency %0dx%0d: got %0d want 5", a, b, lat); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignore_start;
    test_reset_midrun;
    test_exhaustive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
